// File: rtl/dma_peripheral_endpoint_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ep_pkg
//  Purpose  : Shared types and default widths for the DMA peripheral endpoint:
//             handshake FSM state encoding, transfer direction encoding and
//             default parameter values.
//  Revision : 1.0 - initial release
// ============================================================================
package dma_ep_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_DEPTH  = 8;
    localparam int c_DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ACK     = 3'd2,
        STROBE  = 3'd3,
        RECOVER = 3'd4
    } dma_ep_state_e;

    typedef enum logic {
        DEV2MEM = 1'b0,   // controller reads from us with IOR_N
        MEM2DEV = 1'b1    // controller writes to us with IOW_N
    } dma_ep_mode_e;

endpackage
`default_nettype wire

// File: rtl/dma_peripheral_endpoint_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_peripheral_endpoint_if
//  Purpose  : Bundles the DMA channel handshake (DREQ/DACK, strobes, EOP,
//             data bus) and the local source/sink streams of the endpoint.
//  Modports : slave  - the endpoint itself
//             master - the environment (DMA controller + local logic)
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_peripheral_endpoint_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();

    logic              MODE;
    logic              DREQ;
    logic              DACK;
    logic              IOR_N;
    logic              IOW_N;
    logic              EOP_N;
    logic [DATA_W-1:0] DB_IN;
    logic [DATA_W-1:0] DB_OUT;
    logic              DB_OE;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              sink_valid;
    logic [DATA_W-1:0] sink_data;
    logic              sink_ready;
    logic [CNT_W-1:0]  xfer_count;
    logic              tc;

    modport slave (
        input  MODE, DACK, IOR_N, IOW_N, EOP_N, DB_IN,
        input  src_valid, src_data, sink_ready,
        output DREQ, DB_OUT, DB_OE, src_ready,
        output sink_valid, sink_data, xfer_count, tc
    );

    modport master (
        output MODE, DACK, IOR_N, IOW_N, EOP_N, DB_IN,
        output src_valid, src_data, sink_ready,
        input  DREQ, DB_OUT, DB_OE, src_ready,
        input  sink_valid, sink_data, xfer_count, tc
    );

endinterface
`default_nettype wire

// File: rtl/dma_peripheral_endpoint_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ep_fifo
//  Purpose  : Synchronous FIFO, DATA_W x DEPTH. Push and pop may occur in the
//             same cycle; at full a pop frees the slot the push uses, at empty
//             a pop is ignored (no bypass path).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             i_push/i_push_data - write side
//             i_pop / o_head     - read side, o_head is the oldest entry
//             o_full / o_empty   - status
//  Revision : 1.0 - initial release
// ============================================================================
module dma_ep_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_pop,
    output logic [DATA_W-1:0]      o_head,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_head   = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
                r_wr_ptr <= r_wr_ptr + {{c_AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{c_AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_peripheral_endpoint.sv
`default_nettype none
// ============================================================================
//  Module   : dma_peripheral_endpoint
//  Purpose  : Device side of an 8237-style DMA channel. Raises DREQ when the
//             latched direction has work (TX byte available / RX space),
//             then sources one byte per IOR_N strobe or sinks one byte per
//             IOW_N strobe, bridging to local valid/ready streams via a TX
//             and an RX FIFO.
//  Ports    : CLK, RESET - clock, synchronous active-high reset
//             bus        - dma_peripheral_endpoint_if.slave (DMA handshake,
//                          data bus, src/sink streams, xfer_count, tc)
//  Options  : DMA_EP_EOP_EN - when defined, EOP_N (with DACK) ends the
//             process: tc pulse, xfer_count cleared, FSM forced to IDLE.
//             When undefined EOP_N is ignored and tc stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_peripheral_endpoint
    import dma_ep_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = c_DEF_DEPTH,
    parameter int CNT_W  = c_DEF_CNT_W
) (
    input  wire logic CLK,
    input  wire logic RESET,
    dma_peripheral_endpoint_if.slave bus
);

    dma_ep_state_e     r_state;
    dma_ep_mode_e      r_mode;
    logic              r_dreq;
    logic [DATA_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_xfer_count;
    logic              r_tc;
    logic              r_eop_seen;
    logic              r_live;

    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_rx_push;

    logic              w_rd_strobe;
    logic              w_wr_strobe;
    logic              w_mode_strobe;
    logic              w_release;
    logic              w_start;
    logic              w_eop_now;
    logic              w_eop_end;
    logic              w_complete;

    // Exactly one strobe low; both low is treated as no valid strobe.
    assign w_rd_strobe   = !bus.IOR_N && bus.IOW_N;
    assign w_wr_strobe   = !bus.IOW_N && bus.IOR_N;
    assign w_mode_strobe = (r_mode == DEV2MEM) ? w_rd_strobe : w_wr_strobe;
    assign w_release     = (r_mode == DEV2MEM) ? bus.IOR_N : bus.IOW_N;

    // Direction taken from the live MODE pin, since it is latched on this edge.
    assign w_start = (dma_ep_mode_e'(bus.MODE) == DEV2MEM) ? !w_tx_empty : !w_rx_full;

`ifdef DMA_EP_EOP_EN
    assign w_eop_now = bus.DACK && !bus.EOP_N;
`else
    logic w_unused_eop;
    assign w_eop_now    = 1'b0;
    assign w_unused_eop = bus.EOP_N;
`endif

    assign w_eop_end  = r_eop_seen || w_eop_now;
    assign w_complete = (r_state == STROBE) && bus.DACK && w_release;
    assign w_tx_pop   = w_complete && (r_mode == DEV2MEM);
    assign w_rx_push  = w_complete && (r_mode == MEM2DEV);
    assign w_tx_push  = bus.src_valid && bus.src_ready;

    // Read data is driven combinationally so it is valid in the same cycle
    // the controller samples IOR_N low, including the first (ACK) cycle.
    assign bus.DB_OE  = ((r_state == ACK) || (r_state == STROBE)) &&
                        (r_mode == DEV2MEM) && bus.DACK && w_rd_strobe;
    assign bus.DB_OUT = bus.DB_OE ? w_tx_head : '0;

    assign bus.DREQ       = r_dreq;
    assign bus.src_ready  = r_live && !w_tx_full;
    assign bus.sink_valid = !w_rx_empty;
    assign bus.sink_data  = w_rx_head;
    assign bus.xfer_count = r_xfer_count;
    assign bus.tc         = r_tc;

    dma_ep_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .i_push      (w_tx_push),
        .i_push_data (bus.src_data),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty)
    );

    dma_ep_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .i_push      (w_rx_push),
        .i_push_data (r_hold),
        .i_pop       (bus.sink_ready),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_mode       <= DEV2MEM;
            r_dreq       <= 1'b0;
            r_hold       <= '0;
            r_xfer_count <= '0;
            r_tc         <= 1'b0;
            r_eop_seen   <= 1'b0;
            r_live       <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_tc   <= 1'b0;

            // EOP may arrive anywhere in the acknowledged cycle; remember it
            // until the current transfer resolves.
            if (w_eop_now && (r_state != IDLE) && (r_state != RECOVER)) begin
                r_eop_seen <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_dreq <= 1'b0;
                    if (w_start) begin
                        r_mode  <= dma_ep_mode_e'(bus.MODE);
                        r_dreq  <= 1'b1;
                        r_state <= REQ;
                    end
                end

                REQ: begin
                    if (bus.DACK) begin
                        r_state <= ACK;
                    end
                end

                ACK: begin
                    if (!bus.DACK) begin
                        r_state <= REQ;
                    end else if (w_mode_strobe) begin
                        r_state <= STROBE;
                        if (r_mode == MEM2DEV) begin
                            r_hold <= bus.DB_IN;
                        end
                    end
                end

                STROBE: begin
                    if (!bus.DACK) begin
                        // Aborted: nothing moves through the FIFOs.
                        r_dreq     <= 1'b0;
                        r_eop_seen <= 1'b0;
                        r_state    <= RECOVER;
                    end else if (w_release) begin
                        r_dreq     <= 1'b0;
                        r_eop_seen <= 1'b0;
                        if (w_eop_end) begin
                            r_xfer_count <= '0;
                            r_tc         <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_xfer_count <= r_xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
                            r_state      <= RECOVER;
                        end
                    end else if ((r_mode == MEM2DEV) && w_wr_strobe) begin
                        r_hold <= bus.DB_IN;
                    end
                end

                RECOVER: begin
                    r_dreq  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_dreq  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dma_peripheral_endpoint.md
# dma_peripheral_endpoint

Device-side endpoint of the 8237-style DMA handshake: the I/O peripheral that raises DREQ, waits for DACK, and sources or sinks one byte per IOR_N/IOW_N strobe. It sits opposite one channel of the DMA controller (one DREQ/DACK bit pair) and bridges that channel to a local valid/ready stream through two small FIFOs. The block doubles as the bench's active peripheral model and as a synthesizable device front-end.

## Interface
Parameters:
- DATA_W, 8, bus data width.
- DEPTH, 8, entries per FIFO; power of two, ≥2.
- CNT_W, 16, width of transfer counter.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- MODE  in  1  0 = device→memory (DMA reads via IOR_N), 1 = memory→device (DMA writes via IOW_N); sampled only in IDLE.
- DREQ  out  1  DMA request to controller, active-high.
- DACK  in  1  DMA acknowledge for this channel, active-high.
- IOR_N  in  1  I/O read strobe, active-low.
- IOW_N  in  1  I/O write strobe, active-low.
- EOP_N  in  1  end-of-process from controller, active-low.
- DB_IN  in  DATA_W  bus data driven by controller/memory during IOW_N.
- DB_OUT  out  DATA_W  bus data to controller during IOR_N.
- DB_OE  out  1  DB_OUT enable.
- src_valid/src_data/src_ready  in/in/out  1/DATA_W/1  local bytes into TX FIFO.
- sink_valid/sink_data/sink_ready  out/out/in  1/DATA_W/1  bytes from RX FIFO to local logic.
- xfer_count  out  CNT_W  completed transfers since reset/EOP.
- tc  out  1  one-cycle pulse on terminal count (EOP seen).

## Operation
- FSM states: IDLE, REQ, ACK, STROBE, RECOVER.
- IDLE → REQ when (MODE=0 and TX non-empty) or (MODE=1 and RX not full); MODE latched here.
- REQ: DREQ=1. → ACK when DACK=1.
- ACK: DREQ=1. → STROBE when DACK=1 and the mode's strobe is low. DACK dropping before a strobe → REQ (re-request, no transfer).
- STROBE: DREQ=1. Read mode: DB_OE=1, DB_OUT=TX head. Write mode: DB_IN captured into hold register every cycle strobe is low. On strobe deasserting (sampled high): transfer completes — read mode pops TX, write mode pushes hold register into RX; xfer_count+1 (wraps at 2^CNT_W); → RECOVER.
- RECOVER: DREQ=0 for exactly one cycle (single-transfer mode), → IDLE.
- Wrong-mode strobe (e.g. IOW_N low in read mode) is ignored; no transfer, no DB_OE.
- Both strobes low simultaneously: treated as wrong-mode; no transfer.
- DACK deasserted during STROBE: transfer aborted, no pop/push, → RECOVER.
- Local side: src_ready = TX not full; sink_valid = RX not empty; FIFOs allow simultaneous push and pop, including at full (pop frees a slot same cycle) and empty (no bypass).

## Timing
- All outputs registered except DB_OE/DB_OUT, which are combinational from state, DACK and strobe so data is valid the same cycle IOR_N is sampled low.
- DREQ rises one cycle after IDLE condition becomes true.
- Minimum handshake: REQ, ACK, STROBE, RECOVER = 4 cycles plus strobe width.
- RESET values: DREQ=0, DB_OE=0, DB_OUT=0, src_ready=0 during reset then 1, sink_valid=0, sink_data=0, xfer_count=0, tc=0; FIFOs empty; state IDLE. RESET mid-transfer discards the in-flight byte.

## Configuration
- DMA_EP_EOP_EN defined: EOP_N sampled low while DACK=1 ends the current transfer (it still completes on strobe release), pulses tc one cycle after completion, clears xfer_count to 0, forces IDLE and holds DREQ=0 until MODE-latched FIFO condition is re-evaluated one cycle later.
- Undefined: EOP_N ignored, tc tied 0, xfer_count free-runs.

## Structure
- Package dma_ep_pkg: state enum (IDLE, REQ, ACK, STROBE, RECOVER), mode enum (DEV2MEM, MEM2DEV), default width constants.
- One sub-module: dma_ep_fifo (synchronous FIFO, DATA_W × DEPTH, full/empty, simultaneous push/pop), instantiated twice (TX, RX).

## Test plan
- Push 0xA5 to TX, MODE=0; DREQ rises; drive DACK=1, IOR_N low 2 cycles → DB_OE=1, DB_OUT=0xA5; after IOR_N high TX empty, xfer_count=1, DREQ low one cycle, stays low.
- MODE=1, DB_IN=0x3C with IOW_N low 3 cycles under DACK → sink_valid=1, sink_data=0x3C, xfer_count=1.
- Fill RX to DEPTH=8 with sink_ready=0 → DREQ stays 0; assert sink_ready one cycle → DREQ reasserts.
- DACK drops mid-STROBE in read mode → no pop, xfer_count unchanged, DREQ re-raises after RECOVER.
- IOW_N low in MODE=0 with DACK=1 → DB_OE=0, no FIFO change.
- With DMA_EP_EOP_EN: EOP_N low during third transfer → tc pulse, xfer_count=0; without macro → xfer_count=3, tc=0.
